mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 61, doubleword address width (byte address bits 0:60).
REQ-002 SHALL have parameter DATA_W, default 64, memory read data width.
REQ-003 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles, legal range 1..4.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-005 SHALL have ports: if_req in 1 fetch request; if_addr in ADDR_W fetch address; if_gnt out 1 fetch accepted; if_rvalid out 1 fetch data valid; if_rdata out DATA_W fetch data.
REQ-006 SHALL have ports: ld_req in 1 load request; ld_addr in ADDR_W load address; ld_gnt out 1 load accepted; ld_rvalid out 1 load data valid; ld_rdata out DATA_W load data.
REQ-007 SHALL have ports: mem_addr out ADDR_W address to the shared read port; mem_data in DATA_W read port data.

Function
REQ-008 SHALL keep at most one request outstanding; FSM states IDLE and WAIT.
REQ-009 In IDLE with any req high, SHALL grant one requester for exactly one cycle, register its address onto mem_addr, record the owner, load lat_cnt=MEM_LAT, and go to WAIT.
REQ-010 In WAIT, SHALL decrement lat_cnt each cycle; when lat_cnt reaches 1, it SHALL capture mem_data into the owner's rdata, pulse the owner's rvalid for one cycle, and return to IDLE.
REQ-011 SHALL allow a new grant in the same cycle rvalid pulses (back-to-back), giving 1 grant per MEM_LAT+... cycles; for MEM_LAT=1, one grant every cycle.
REQ-012 With a single requester active, SHALL grant that requester.
REQ-013 With both requesters active, SHALL grant the one not granted last (round-robin); after reset, the load requester wins the first conflict.
REQ-014 Requesters SHALL hold req and addr stable until gnt; the arbiter samples addr only in the grant cycle.
REQ-015 if_gnt and ld_gnt SHALL never be high in the same cycle; rvalid SHALL go only to the recorded owner.
REQ-016 mem_addr SHALL hold its last granted value while idle; rdata SHALL hold until next own rvalid.
REQ-017 A req deasserted before gnt SHALL be dropped with no side effects.

Reset
REQ-018 On rst, SHALL set state=IDLE, lat_cnt=0, last-grant=fetch, mem_addr=0, all gnt/rvalid=0, and both rdata=0, regardless of the clock.
REQ-019 Reset during WAIT SHALL abandon the outstanding read; no rvalid SHALL follow.
REQ-020 The first grant SHALL be possible in the first clk edge after rst deasserts.

Configuration
REQ-021 With MEM_ARB_STATS_EN defined, SHALL add 32-bit outputs if_gnt_cnt, ld_gnt_cnt, and conflict_cnt (cycles with both req high and no grant to one of them, counted per cycle), reset to 0 and wrapping at 2^32.
REQ-022 Without MEM_ARB_STATS_EN, those ports and counters SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-023 Shared package ppc_mem_pkg SHALL hold DOUBLEWORD_ADDR_W=61, DOUBLEWORD_W=64, the FSM state encoding (IDLE=0, WAIT=1), and owner encoding (OWN_IF=0, OWN_LD=1).
REQ-024 Round-robin selection SHALL be a sub-module rr_pick2 (inputs req0, req1, last; output one-hot grant); everything else is in mem_port_arbiter.

Verification
REQ-025 MEM_LAT=1, if_req alone, if_addr=0x10 -> if_gnt cycle N, mem_addr=0x10, if_rvalid N+1 with if_rdata=mem_data at N+1.
REQ-026 Both req held from reset, if_addr=0x20, ld_addr=0x30 -> grants ld, if, ld, if on consecutive cycles; rvalid follows owner.
REQ-027 MEM_LAT=3, ld_req pulse, ld_addr=0x5 -> ld_gnt N, ld_rvalid N+3 only, no grant in N+1..N+2 despite if_req high.
REQ-028 MEM_LAT=3, rst asserted at N+1 after grant -> no rvalid ever, all outputs 0, next grant at first edge after release.
REQ-029 if_req dropped before gnt while ld busy -> no if_gnt, no if_rvalid.
REQ-030 MEM_ARB_STATS_EN, 10 conflict cycles -> if_gnt_cnt=5, ld_gnt_cnt=5, conflict_cnt=10.

Source files
------------

// File: rtl/ppc_mem_pkg.sv
// ---------------------------------------------------------------------------
// ppc_mem_pkg
// Shared definitions for the memory-side blocks: doubleword address and data
// widths, the read-port arbiter FSM state encoding and the owner encoding
// used to route read responses back to the fetch or load requester.
// ---------------------------------------------------------------------------
package ppc_mem_pkg;

    // Byte address bits 0:60 select a doubleword.
    localparam int DOUBLEWORD_ADDR_W = 61;
    localparam int DOUBLEWORD_W      = 64;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arbState_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } owner_t;

endpackage : ppc_mem_pkg

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin pick. A lone requester always wins; when both request,
// the one that did not win last time is chosen.
//
// Ports:
//   req0  in  1  request from port 0 (fetch)
//   req1  in  1  request from port 1 (load)
//   last  in  1  owner of the most recent grant
//   grant out 2  one-hot pick, all zero when nobody requests
// ---------------------------------------------------------------------------
module rr_pick2
    import ppc_mem_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  owner_t     last,
    output logic [1:0] grant
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            grant = (last == OWN_LD) ? 2'b01 : 2'b10;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end

endmodule : rr_pick2

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one read port of latency MEM_LAT (1..4) between the instruction
// fetch and the load unit. At most one read is outstanding. A grant is a
// one-cycle registered pulse that coincides with the granted address
// appearing on mem_addr; the response is captured into the owner's rdata and
// flagged with a one-cycle rvalid MEM_LAT cycles later. A new grant may be
// issued in the same cycle as that rvalid, so MEM_LAT=1 sustains one read
// per cycle.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   if_req/if_addr           fetch request and its doubleword address
//   if_gnt                   fetch request accepted (one-cycle pulse)
//   if_rvalid/if_rdata       fetch response; rdata holds until next rvalid
//   ld_req/ld_addr           load request and its doubleword address
//   ld_gnt                   load request accepted (one-cycle pulse)
//   ld_rvalid/ld_rdata       load response; rdata holds until next rvalid
//   mem_addr                 address to the shared read port (holds when idle)
//   mem_data                 read port data
//   if_gnt_cnt, ld_gnt_cnt,  wrapping 32-bit grant and conflict counters,
//   conflict_cnt             present only when MEM_ARB_STATS_EN is defined
//
// Build option: MEM_ARB_STATS_EN adds the statistics counters.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import ppc_mem_pkg::*;
#(
    parameter int ADDR_W  = DOUBLEWORD_ADDR_W,
    parameter int DATA_W  = DOUBLEWORD_W,
    parameter int MEM_LAT = 1
)
(
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,

`ifdef MEM_ARB_STATS_EN
    output logic [31:0]       if_gnt_cnt,
    output logic [31:0]       ld_gnt_cnt,
    output logic [31:0]       conflict_cnt,
`endif

    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data
);

    // Wide enough for MEM_LAT up to 4.
    localparam int CNT_W = 3;

    arbState_t  state, stateNext;
    logic [CNT_W-1:0] latCnt, latCntNext;

    // The owner of the outstanding read doubles as the round-robin history:
    // both always name the most recently granted requester.
    owner_t     owner;

    logic [1:0] pick;
    logic       canGrant;
    logic       doGrant;
    logic       respond;

    rr_pick2 u_pick (
        .req0  (if_req),
        .req1  (ld_req),
        .last  (owner),
        .grant (pick)
    );

    // ---------------- FSM state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            latCnt <= '0;
        end else begin
            state  <= stateNext;
            latCnt <= latCntNext;
        end
    end

    // ---------------- FSM next-state / decisions ----------------
    always_comb begin
        stateNext  = state;
        latCntNext = latCnt;
        canGrant   = 1'b0;
        respond    = 1'b0;

        unique case (state)
            IDLE: begin
                canGrant = 1'b1;
            end
            WAIT: begin
                latCntNext = latCnt - CNT_W'(1);
                if (latCnt == CNT_W'(1)) begin
                    // Final wait cycle: data is on mem_data now, and the port
                    // is free again for a back-to-back grant.
                    respond   = 1'b1;
                    canGrant  = 1'b1;
                    stateNext = IDLE;
                end
            end
        endcase

        doGrant = canGrant && (pick != 2'b00);
        if (doGrant) begin
            stateNext  = WAIT;
            latCntNext = CNT_W'(MEM_LAT);
        end
    end

    // ---------------- Grant / response datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_IF;
            mem_addr  <= '0;
            if_gnt    <= 1'b0;
            ld_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ld_rvalid <= 1'b0;
            if_rdata  <= '0;
            ld_rdata  <= '0;
        end else begin
            if_gnt    <= doGrant && pick[0];
            ld_gnt    <= doGrant && pick[1];
            if_rvalid <= respond && (owner == OWN_IF);
            ld_rvalid <= respond && (owner == OWN_LD);

            if (respond && (owner == OWN_IF)) begin
                if_rdata <= mem_data;
            end
            if (respond && (owner == OWN_LD)) begin
                ld_rdata <= mem_data;
            end

            // The owner update reads the pre-edge owner above, so the
            // response still routes to the requester that issued it.
            if (doGrant) begin
                owner    <= pick[1] ? OWN_LD : OWN_IF;
                mem_addr <= pick[1] ? ld_addr : if_addr;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    // ---------------- Statistics ----------------
    // A conflict is any cycle in which both requesters ask at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_gnt_cnt   <= '0;
            ld_gnt_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (doGrant && pick[0]) begin
                if_gnt_cnt <= if_gnt_cnt + 32'd1;
            end
            if (doGrant && pick[1]) begin
                ld_gnt_cnt <= ld_gnt_cnt + 32'd1;
            end
            if (if_req && ld_req) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiter instances share one clock: index 0 is built with MEM_LAT=1,
// index 1 with MEM_LAT=3. Each has its own reset, requesters and a
// combinational memory model on its read port. Expected responses are
// queued when requests are driven and matched against rvalid pulses by a
// monitor. Statistics ports are exercised when MEM_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 61;
    localparam int DATA_W = 64;

    typedef struct {
        logic              owner;   // 0 = fetch, 1 = load
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst       [2];
    logic ifReq     [2];
    logic ldReq     [2];
    logic ifGnt     [2];
    logic ldGnt     [2];
    logic ifRvalid  [2];
    logic ldRvalid  [2];
    logic [ADDR_W-1:0] ifAddr  [2];
    logic [ADDR_W-1:0] ldAddr  [2];
    logic [ADDR_W-1:0] memAddr [2];
    logic [DATA_W-1:0] memData [2];
    logic [DATA_W-1:0] ifRdata [2];
    logic [DATA_W-1:0] ldRdata [2];
`ifdef MEM_ARB_STATS_EN
    logic [31:0] ifGntCnt    [2];
    logic [31:0] ldGntCnt    [2];
    logic [31:0] conflictCnt [2];
`endif

    int checks   = 0;
    int failures = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    // Memory contents: an arbitrary but fixed function of the address.
    function automatic logic [DATA_W-1:0] memModel(input logic [ADDR_W-1:0] a);
        return {a, 3'b011} ^ 64'hC3C3_5A5A_0F0F_9696;
    endfunction

    assign memData[0] = memModel(memAddr[0]);
    assign memData[1] = memModel(memAddr[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst[0]),
        .if_req       (ifReq[0]),
        .if_addr      (ifAddr[0]),
        .if_gnt       (ifGnt[0]),
        .if_rvalid    (ifRvalid[0]),
        .if_rdata     (ifRdata[0]),
        .ld_req       (ldReq[0]),
        .ld_addr      (ldAddr[0]),
        .ld_gnt       (ldGnt[0]),
        .ld_rvalid    (ldRvalid[0]),
        .ld_rdata     (ldRdata[0]),
`ifdef MEM_ARB_STATS_EN
        .if_gnt_cnt   (ifGntCnt[0]),
        .ld_gnt_cnt   (ldGntCnt[0]),
        .conflict_cnt (conflictCnt[0]),
`endif
        .mem_addr     (memAddr[0]),
        .mem_data     (memData[0])
    );

    mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
        .clk          (clk),
        .rst          (rst[1]),
        .if_req       (ifReq[1]),
        .if_addr      (ifAddr[1]),
        .if_gnt       (ifGnt[1]),
        .if_rvalid    (ifRvalid[1]),
        .if_rdata     (ifRdata[1]),
        .ld_req       (ldReq[1]),
        .ld_addr      (ldAddr[1]),
        .ld_gnt       (ldGnt[1]),
        .ld_rvalid    (ldRvalid[1]),
        .ld_rdata     (ldRdata[1]),
`ifdef MEM_ARB_STATS_EN
        .if_gnt_cnt   (ifGntCnt[1]),
        .ld_gnt_cnt   (ldGntCnt[1]),
        .conflict_cnt (conflictCnt[1]),
`endif
        .mem_addr     (memAddr[1]),
        .mem_data     (memData[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pushExp(input int d, input logic owner, input logic [ADDR_W-1:0] a);
        exp_t e;
        e.owner = owner;
        e.data  = memModel(a);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Response monitor: grant exclusivity every cycle, and every rvalid must
    // match the oldest queued expectation of its instance.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("gnt_exclusive_d%0d", d), 64'(ifGnt[d] & ldGnt[d]), 64'd0);
            if (ifRvalid[d] || ldRvalid[d]) begin
                exp_t e;
                int   depth;
                depth = (d == 0) ? sb0.size() : sb1.size();
                check($sformatf("rvalid_exclusive_d%0d", d), 64'(ifRvalid[d] & ldRvalid[d]), 64'd0);
                if (depth == 0) begin
                    check($sformatf("unexpected_rvalid_d%0d", d), 64'(ifRvalid[d] | ldRvalid[d]), 64'd0);
                end else begin
                    e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                    check($sformatf("rvalid_owner_d%0d", d), 64'(ldRvalid[d]), 64'(e.owner));
                    check($sformatf("rdata_d%0d", d), ldRvalid[d] ? ldRdata[d] : ifRdata[d], e.data);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]    = 1'b1;
            ifReq[d]  = 1'b0;
            ldReq[d]  = 1'b0;
            ifAddr[d] = '0;
            ldAddr[d] = '0;
        end
        @(negedge clk);
        @(negedge clk);

        // ---- Reset state of both instances ----
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_if_gnt_d%0d", d),    64'(ifGnt[d]),    64'd0);
            check($sformatf("rst_ld_gnt_d%0d", d),    64'(ldGnt[d]),    64'd0);
            check($sformatf("rst_if_rvalid_d%0d", d), 64'(ifRvalid[d]), 64'd0);
            check($sformatf("rst_ld_rvalid_d%0d", d), 64'(ldRvalid[d]), 64'd0);
            check($sformatf("rst_if_rdata_d%0d", d),  ifRdata[d],       64'd0);
            check($sformatf("rst_ld_rdata_d%0d", d),  ldRdata[d],       64'd0);
            check($sformatf("rst_mem_addr_d%0d", d),  64'(memAddr[d]),  64'd0);
        end
        rst[1] = 1'b0;

        // ---- MEM_LAT=1: both requesters held from reset alternate ld, if ----
        ifReq[0]  = 1'b1;
        ifAddr[0] = 61'h20;
        ldReq[0]  = 1'b1;
        ldAddr[0] = 61'h30;
        for (int k = 0; k < 10; k++) begin
            pushExp(0, (k % 2 == 0), (k % 2 == 0) ? 61'h30 : 61'h20);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("rr_ld_gnt_%0d", k), 64'(ldGnt[0]), 64'(k % 2 == 0));
            check($sformatf("rr_if_gnt_%0d", k), 64'(ifGnt[0]), 64'(k % 2 == 1));
            check($sformatf("rr_mem_addr_%0d", k), 64'(memAddr[0]), (k % 2 == 0) ? 64'h30 : 64'h20);
        end
        ifReq[0] = 1'b0;
        ldReq[0] = 1'b0;
        tick();
        check("rr_no_gnt_after_drop", 64'(ifGnt[0] | ldGnt[0]), 64'd0);
        tick();
`ifdef MEM_ARB_STATS_EN
        check("stats_if_gnt_cnt",   64'(ifGntCnt[0]),    64'd5);
        check("stats_ld_gnt_cnt",   64'(ldGntCnt[0]),    64'd5);
        check("stats_conflict_cnt", 64'(conflictCnt[0]), 64'd10);
`endif

        // ---- MEM_LAT=1: single fetch, one-cycle response ----
        ifReq[0]  = 1'b1;
        ifAddr[0] = 61'h10;
        pushExp(0, 1'b0, 61'h10);
        tick();
        check("lat1_if_gnt",   64'(ifGnt[0]),   64'd1);
        check("lat1_ld_gnt",   64'(ldGnt[0]),   64'd0);
        check("lat1_mem_addr", 64'(memAddr[0]), 64'h10);
        ifReq[0] = 1'b0;
        tick();
        check("lat1_if_rvalid",  64'(ifRvalid[0]), 64'd1);
        check("lat1_if_rdata",   ifRdata[0],       memModel(61'h10));
        check("lat1_if_gnt_off", 64'(ifGnt[0]),    64'd0);
        check("lat1_ld_rdata_hold", ldRdata[0],    memModel(61'h30));
        tick();
        check("lat1_mem_addr_hold", 64'(memAddr[0]), 64'h10);
        check("lat1_if_rvalid_off", 64'(ifRvalid[0]), 64'd0);

        // ---- MEM_LAT=3: load pulse, no grant while busy, back-to-back fetch ----
        ldReq[1]  = 1'b1;
        ldAddr[1] = 61'h5;
        pushExp(1, 1'b1, 61'h5);
        tick();
        check("lat3_ld_gnt", 64'(ldGnt[1]), 64'd1);
        ldReq[1]  = 1'b0;
        ifReq[1]  = 1'b1;
        ifAddr[1] = 61'h44;
        pushExp(1, 1'b0, 61'h44);
        for (int k = 1; k <= 2; k++) begin
            tick();
            check($sformatf("lat3_busy_if_gnt_%0d", k),    64'(ifGnt[1]),    64'd0);
            check($sformatf("lat3_busy_ld_rvalid_%0d", k), 64'(ldRvalid[1]), 64'd0);
        end
        tick();
        check("lat3_ld_rvalid", 64'(ldRvalid[1]), 64'd1);
        check("lat3_ld_rdata",  ldRdata[1],       memModel(61'h5));
        check("lat3_b2b_if_gnt", 64'(ifGnt[1]),   64'd1);
        check("lat3_b2b_mem_addr", 64'(memAddr[1]), 64'h44);
        ifReq[1] = 1'b0;
        tick();
        tick();
        tick();
        check("lat3_if_rvalid", 64'(ifRvalid[1]), 64'd1);
        check("lat3_if_rdata",  ifRdata[1],       memModel(61'h44));

        // ---- MEM_LAT=3: fetch request withdrawn before grant ----
        ldReq[1]  = 1'b1;
        ldAddr[1] = 61'h7;
        pushExp(1, 1'b1, 61'h7);
        tick();
        check("drop_ld_gnt", 64'(ldGnt[1]), 64'd1);
        ldReq[1]  = 1'b0;
        ifReq[1]  = 1'b1;
        ifAddr[1] = 61'h99;
        tick();
        ifReq[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("drop_no_if_gnt_%0d", k),    64'(ifGnt[1]),    64'd0);
            check($sformatf("drop_no_if_rvalid_%0d", k), 64'(ifRvalid[1]), 64'd0);
        end

        // ---- MEM_LAT=3: reset while a read is outstanding ----
        ldReq[1]  = 1'b1;
        ldAddr[1] = 61'h123;
        tick();
        check("rstw_ld_gnt", 64'(ldGnt[1]), 64'd1);
        ldReq[1] = 1'b0;
        tick();
        rst[1] = 1'b1;
        #1;
        check("rstw_ld_gnt_0",    64'(ldGnt[1]),    64'd0);
        check("rstw_if_gnt_0",    64'(ifGnt[1]),    64'd0);
        check("rstw_ld_rvalid_0", 64'(ldRvalid[1]), 64'd0);
        check("rstw_if_rvalid_0", 64'(ifRvalid[1]), 64'd0);
        check("rstw_ld_rdata_0",  ldRdata[1],       64'd0);
        check("rstw_if_rdata_0",  ifRdata[1],       64'd0);
        check("rstw_mem_addr_0",  64'(memAddr[1]),  64'd0);
        ldReq[1]  = 1'b1;
        ldAddr[1] = 61'h55;
        pushExp(1, 1'b1, 61'h55);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rstw_held_ld_rvalid_%0d", k), 64'(ldRvalid[1]), 64'd0);
            check($sformatf("rstw_held_ld_gnt_%0d", k),    64'(ldGnt[1]),    64'd0);
        end
        rst[1] = 1'b0;
        tick();
        check("rstw_first_gnt",  64'(ldGnt[1]),   64'd1);
        check("rstw_first_addr", 64'(memAddr[1]), 64'h55);
        ldReq[1] = 1'b0;
        tick();
        tick();
        tick();
        check("rstw_ld_rvalid", 64'(ldRvalid[1]), 64'd1);

        // ---- Drain: every queued response must have arrived ----
        for (int i = 0; i < 20 && (sb0.size() + sb1.size()) != 0; i++) begin
            tick();
        end
        check("scoreboard_drained", 64'(sb0.size() + sb1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_port_arbiter
